duty_ramp: RTL

Breathing-envelope generator that produces the duty-cycle word consumed by the LED PWM comparator stage. It ramps a duty value up and down between 0 and full scale, with a programmable step size, step rate and dwell time. Duty updates are aligned to the PWM counter wrap, so the comparator never sees a mid-period change. It sits directly upstream of the PWM stage: `duty` drives the PWM width register, and `period_wrap` comes back from the PWM counter.

---
 rtl/duty_ramp_if.sv | 27 ++
 rtl/duty_ramp.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/duty_ramp_if.sv
// Control/config/status bundle between the breathing-envelope generator and its host.
interface duty_ramp_if #(
  parameter int WIDTH      = 11,
  parameter int DIV_WIDTH  = 16,
  parameter int HOLD_WIDTH = 8
);
  logic                  enable;
  logic                  period_wrap;
  logic [DIV_WIDTH-1:0]  step_div;
  logic [3:0]            step_size;
  logic [HOLD_WIDTH-1:0] hold_periods;
  logic [WIDTH-1:0]      duty;
  logic                  duty_load;
  logic [2:0]            state;
  logic                  at_top;
  logic                  at_bottom;

  modport master (
    output enable, period_wrap, step_div, step_size, hold_periods,
    input  duty, duty_load, state, at_top, at_bottom
  );

  modport slave (
    input  enable, period_wrap, step_div, step_size, hold_periods,
    output duty, duty_load, state, at_top, at_bottom
  );
endinterface

// File: rtl/duty_ramp.sv
// Breathing-envelope generator feeding the LED PWM width register; steps align to PWM wraps.
// Optional square-law duty mapping enabled by defining DUTY_RAMP_GAMMA_EN.
//
// state   | meaning
// IDLE    | dark, lin held at 0; leaves on enable
// RISE    | lin steps up on each tick until MAX
// HOLD_HI | dwell at MAX for hold_periods+1 wraps
// FALL    | lin steps down on each tick until 0
// HOLD_LO | dwell at 0 for hold_periods+1 wraps
module duty_ramp #(
  parameter int WIDTH      = 11,
  parameter int DIV_WIDTH  = 16,
  parameter int HOLD_WIDTH = 8
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  duty_ramp_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RISE    = 3'd1,
    HOLD_HI = 3'd2,
    FALL    = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  state_t                state_q, state_d;
  logic [WIDTH-1:0]      lin_q, lin_d;
  logic [WIDTH-1:0]      duty_q, duty_d;
  logic                  duty_load_q;
  logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
  logic [HOLD_WIDTH-1:0] hold_cnt_q, hold_cnt_d;

  logic [DIV_WIDTH-1:0]  step_div_eff;
  logic [3:0]            step_eff;
  logic [WIDTH-1:0]      step_w;
  logic [WIDTH:0]        sum;
  logic                  tick;
  logic                  hold_done;

  always_comb begin
    step_div_eff = (bus.step_div == '0) ? DIV_WIDTH'(1) : bus.step_div;
    step_eff     = (bus.step_size == 4'd0) ? 4'd1 : bus.step_size;
    step_w       = WIDTH'(step_eff);
    sum          = {1'b0, lin_q} + {1'b0, step_w};
    // >= rather than == so a step_div lowered mid-ramp ticks at the next wrap
    tick         = bus.period_wrap && (div_cnt_q >= (step_div_eff - DIV_WIDTH'(1)));
    hold_done    = bus.period_wrap && (hold_cnt_q >= bus.hold_periods);
  end

  always_comb begin
    state_d    = state_q;
    lin_d      = lin_q;
    div_cnt_d  = div_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (!bus.enable) begin
      state_d    = IDLE;
      lin_d      = '0;
      div_cnt_d  = '0;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          lin_d     = '0;
          div_cnt_d = '0;
          state_d   = RISE;
        end
        RISE: begin
          if (tick) begin
            div_cnt_d = '0;
            lin_d     = sum[WIDTH] ? MAX : sum[WIDTH-1:0];
            if (lin_d == MAX) begin
              state_d    = HOLD_HI;
              hold_cnt_d = '0;
            end
          end else if (bus.period_wrap) begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
          end
        end
        HOLD_HI: begin
          if (hold_done) begin
            state_d   = FALL;
            div_cnt_d = '0;
          end else if (bus.period_wrap) begin
            hold_cnt_d = hold_cnt_q + HOLD_WIDTH'(1);
          end
        end
        FALL: begin
          if (tick) begin
            div_cnt_d = '0;
            lin_d     = (lin_q <= step_w) ? '0 : (lin_q - step_w);
            if (lin_d == '0) begin
              state_d    = HOLD_LO;
              hold_cnt_d = '0;
            end
          end else if (bus.period_wrap) begin
            div_cnt_d = div_cnt_q + DIV_WIDTH'(1);
          end
        end
        HOLD_LO: begin
          if (hold_done) begin
            state_d   = RISE;
            div_cnt_d = '0;
          end else if (bus.period_wrap) begin
            hold_cnt_d = hold_cnt_q + HOLD_WIDTH'(1);
          end
        end
        default: begin
          state_d    = IDLE;
          lin_d      = '0;
          div_cnt_d  = '0;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

`ifdef DUTY_RAMP_GAMMA_EN
  logic [2*WIDTH-1:0] lin_sq;

  // Full scale is forced to MAX so the top of the breath reaches 100% duty
  always_comb begin
    lin_sq = {{WIDTH{1'b0}}, lin_d} * {{WIDTH{1'b0}}, lin_d};
    duty_d = (lin_d == MAX) ? MAX : lin_sq[2*WIDTH-1:WIDTH];
  end
`else
  always_comb begin
    duty_d = lin_d;
  end
`endif

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      lin_q       <= '0;
      div_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      duty_q      <= '0;
      duty_load_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lin_q       <= lin_d;
      div_cnt_q   <= div_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      duty_q      <= duty_d;
      duty_load_q <= (duty_d != duty_q);
    end
  end

  assign bus.duty      = duty_q;
  assign bus.duty_load = duty_load_q;
  assign bus.state     = state_q;
  assign bus.at_top    = (lin_q == MAX);
  assign bus.at_bottom = (lin_q == '0);

endmodule
